rv_decode_stage: RTL and testbench

Registered, parametrised RISC-V base-integer decode stage for XLEN = 32 or 64. It accepts a fetched 32-bit instruction and PC over a valid/ready handshake and extracts all fields. It builds the correctly sign-extended XLEN-wide immediate and classifies illegal encodings with a cause code. Results are presented one cycle later through a two-entry skid buffer, giving full throughput. It sits between fetch and register-read/issue.

---
 rtl/rv_decode_stage_pkg.sv | 169 ++++++++++++++++
 rtl/rv_skid_buffer.sv | 67 ++++++
 rtl/rv_decode_stage.sv | 122 ++++++++++++
 tb/tb_rv_decode_stage.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_decode_stage_pkg.sv
// Shared decode definitions for rv_decode_stage: RV32I/RV64I opcodes, funct3
// encodings, decode-error cause codes, immediate format selection and the
// illegal-instruction classifier.
package rv_decode_stage_pkg;

  // Base opcodes (RV32I), plus the two RV64I-only word-op opcodes.
  typedef enum logic [6:0] {
    OpcLoad    = 7'h03,
    OpcMiscMem = 7'h0f,
    OpcOpImm   = 7'h13,
    OpcAuipc   = 7'h17,
    OpcOpImm32 = 7'h1b,
    OpcStore   = 7'h23,
    OpcOp      = 7'h33,
    OpcLui     = 7'h37,
    OpcOp32    = 7'h3b,
    OpcBranch  = 7'h63,
    OpcJalr    = 7'h67,
    OpcJal     = 7'h6f,
    OpcSystem  = 7'h73
  } rv_opcode_e;

  typedef enum logic [2:0] {
    F3Lb  = 3'd0,
    F3Lh  = 3'd1,
    F3Lw  = 3'd2,
    F3Ld  = 3'd3,
    F3Lbu = 3'd4,
    F3Lhu = 3'd5,
    F3Lwu = 3'd6
  } rv_load_f3_e;

  typedef enum logic [2:0] {
    F3Sb = 3'd0,
    F3Sh = 3'd1,
    F3Sw = 3'd2,
    F3Sd = 3'd3
  } rv_store_f3_e;

  // Shared by OP-IMM/OP-IMM-32 (ADDIW, SLLIW, SRLIW/SRAIW) and OP/OP-32.
  typedef enum logic [2:0] {
    F3AddSub = 3'd0,
    F3Sll    = 3'd1,
    F3SrlSra = 3'd5
  } rv_alu_f3_e;

  typedef enum logic [2:0] {
    F3Priv = 3'd0,
    F3Rsv4 = 3'd4
  } rv_system_f3_e;

  typedef enum logic [2:0] {
    CauseNone    = 3'd0,
    CauseOpcode  = 3'd1,
    CauseFunct3  = 3'd2,
    CauseFunct7  = 3'd3,
    CauseFunct12 = 3'd4
  } rv_decode_cause_t;

  typedef enum logic [2:0] {
    FmtI = 3'd0,
    FmtS = 3'd1,
    FmtB = 3'd2,
    FmtU = 3'd3,
    FmtJ = 3'd4
  } rv_imm_fmt_e;

  function automatic rv_imm_fmt_e imm_format(input logic [6:0] opcode);
    rv_imm_fmt_e fmt;
    case (opcode)
      OpcStore:        fmt = FmtS;
      OpcLui, OpcAuipc: fmt = FmtU;
      OpcJal:          fmt = FmtJ;
      OpcBranch:       fmt = FmtB;
      default:         fmt = FmtI;
    endcase
    return fmt;
  endfunction

  // RV32 immediate shift: SLL needs funct7 0, SRL/SRA accept 0 or 0x20.
  function automatic logic shift32_bad(input logic [2:0] f3, input logic [6:0] f7);
    if (f3 == F3Sll) return f7 != 7'h00;
    return !(f7 == 7'h00 || f7 == 7'h20);
  endfunction

  // RV64 immediate shift: shamt is 6 bits, so only inst[31:26] is checked.
  function automatic logic shift64_bad(input logic [2:0] f3, input logic [5:0] f6);
    if (f3 == F3Sll) return f6 != 6'h00;
    return !(f6 == 6'h00 || f6 == 6'h10);
  endfunction

  // Register-register ops: funct7 0 always, 0x20 only for ADD/SUB and SRL/SRA slots.
  function automatic logic op_f7_bad(input logic [2:0] f3, input logic [6:0] f7);
    return !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == F3AddSub || f3 == F3SrlSra)));
  endfunction

  function automatic rv_decode_cause_t classify(input logic [31:0] inst, input logic rv64);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] f12;
    logic        is_shift;
    logic        opc_ok;
    logic        f3_bad;
    logic        f7_bad;
    logic        f12_bad;
    rv_decode_cause_t cause;

    opc      = inst[6:0];
    f3       = inst[14:12];
    f7       = inst[31:25];
    f12      = inst[31:20];
    is_shift = (f3 == F3Sll) || (f3 == F3SrlSra);
    opc_ok   = 1'b0;
    f3_bad   = 1'b0;
    f7_bad   = 1'b0;
    f12_bad  = 1'b0;

    case (opc)
      OpcLoad: begin
        opc_ok = 1'b1;
        f3_bad = rv64 ? (f3 == 3'd7) : (f3 == F3Ld || f3 == F3Lwu || f3 == 3'd7);
      end
      OpcStore: begin
        opc_ok = 1'b1;
        f3_bad = rv64 ? (f3 > F3Sd) : (f3 > F3Sw);
      end
      OpcBranch: begin
        opc_ok = 1'b1;
        f3_bad = (f3 == 3'd2) || (f3 == 3'd3);
      end
      OpcJalr: begin
        opc_ok = 1'b1;
        f3_bad = (f3 != 3'd0);
      end
      OpcSystem: begin
        opc_ok  = 1'b1;
        f3_bad  = (f3 == F3Rsv4);
        f12_bad = (f3 == F3Priv) && (f12 != 12'h000) && (f12 != 12'h001);
      end
      OpcOp: begin
        opc_ok = 1'b1;
        f7_bad = op_f7_bad(f3, f7);
      end
      OpcOpImm: begin
        opc_ok = 1'b1;
        f7_bad = is_shift && (rv64 ? shift64_bad(f3, inst[31:26]) : shift32_bad(f3, f7));
      end
      OpcOpImm32: begin
        opc_ok = rv64;
        f7_bad = is_shift && shift32_bad(f3, f7);
      end
      OpcOp32: begin
        opc_ok = rv64;
        f7_bad = op_f7_bad(f3, f7);
      end
      OpcLui, OpcAuipc, OpcJal, OpcMiscMem: opc_ok = 1'b1;
      default: opc_ok = 1'b0;
    endcase

    if (!opc_ok || inst[1:0] != 2'b11) cause = CauseOpcode;
    else if (f3_bad)                   cause = CauseFunct3;
    else if (f7_bad)                   cause = CauseFunct7;
    else if (f12_bad)                  cause = CauseFunct12;
    else                               cause = CauseNone;
    return cause;
  endfunction

endpackage

// File: rtl/rv_skid_buffer.sv
// Two-entry valid/ready skid buffer. The primary entry drives the output; the
// secondary entry absorbs the one input accepted in the cycle the output
// stalls. in_ready_o depends only on registered state.
module rv_skid_buffer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);

  logic             prim_valid_q, prim_valid_d;
  logic             sec_valid_q, sec_valid_d;
  logic [Width-1:0] prim_data_q, prim_data_d;
  logic [Width-1:0] sec_data_q, sec_data_d;
  logic             in_fire;
  logic             prim_free;

  assign in_ready_o  = ~sec_valid_q;
  assign out_valid_o = prim_valid_q;
  assign out_data_o  = prim_data_q;

  // Next-state: refill primary from secondary first, else from the input;
  // a stalled primary diverts the input into secondary.
  always_comb begin
    in_fire      = in_valid_i & in_ready_o;
    prim_free    = ~prim_valid_q | out_ready_i;
    prim_valid_d = prim_valid_q;
    prim_data_d  = prim_data_q;
    sec_valid_d  = sec_valid_q;
    sec_data_d   = sec_data_q;
    if (prim_free) begin
      if (sec_valid_q) begin
        prim_valid_d = 1'b1;
        prim_data_d  = sec_data_q;
        sec_valid_d  = 1'b0;
      end else begin
        prim_valid_d = in_fire;
        if (in_fire) prim_data_d = in_data_i;
      end
    end else if (in_fire) begin
      sec_valid_d = 1'b1;
      sec_data_d  = in_data_i;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prim_valid_q <= 1'b0;
      sec_valid_q  <= 1'b0;
      prim_data_q  <= '0;
      sec_data_q   <= '0;
    end else begin
      prim_valid_q <= prim_valid_d;
      sec_valid_q  <= sec_valid_d;
      prim_data_q  <= prim_data_d;
      sec_data_q   <= sec_data_d;
    end
  end

endmodule

// File: rtl/rv_decode_stage.sv
// RISC-V base-integer decode stage (RV32I / RV64I). Combinational field,
// immediate and legality decode in front of a two-entry skid buffer, giving
// one-cycle latency at full throughput. Illegal encodings are flagged with a
// cause code and still passed downstream.
// Optional: define RV_DECODE_STATS_EN to add saturating transfer counters.
module rv_decode_stage
  import rv_decode_stage_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned PC_WIDTH = XLEN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_inst,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [31:0]         out_inst,
  output logic [6:0]          out_opcode,
  output logic [4:0]          out_rd,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [2:0]          out_funct3,
  output logic [6:0]          out_funct7,
  output logic [11:0]         out_funct12,
  output logic [XLEN-1:0]     out_imm,
  output logic                out_illegal,
  output logic [2:0]          out_cause
`ifdef RV_DECODE_STATS_EN
  ,
  output logic [31:0]         stat_decoded,
  output logic [31:0]         stat_illegal
`endif
);

  localparam int unsigned PayloadW = PC_WIDTH + 32 + XLEN + 1 + 3;
  localparam logic        IsRv64   = (XLEN == 64);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("rv_decode_stage: XLEN must be 32 or 64");
  end

  logic [63:0]         imm_i, imm_s, imm_b, imm_u, imm_j, imm_sel;
  logic [XLEN-1:0]     imm_d;
  logic                sgn;
  rv_imm_fmt_e         fmt;
  rv_decode_cause_t    cause_d;
  logic                illegal_d;
  logic [PayloadW-1:0] in_pld;
  logic [PayloadW-1:0] out_pld;

  // Build every immediate format at 64 bits, then select by opcode and trim to XLEN.
  always_comb begin
    sgn   = in_inst[31];
    imm_i = {{52{sgn}}, in_inst[31:20]};
    imm_s = {{52{sgn}}, in_inst[31:25], in_inst[11:7]};
    imm_b = {{51{sgn}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    imm_u = {{32{sgn}}, in_inst[31:12], 12'b0};
    imm_j = {{43{sgn}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    fmt   = imm_format(in_inst[6:0]);
    case (fmt)
      FmtS:    imm_sel = imm_s;
      FmtB:    imm_sel = imm_b;
      FmtU:    imm_sel = imm_u;
      FmtJ:    imm_sel = imm_j;
      default: imm_sel = imm_i;
    endcase
    imm_d = imm_sel[XLEN-1:0];
  end

  // Legality classification; illegal words are tagged, never dropped.
  always_comb begin
    cause_d   = classify(in_inst, IsRv64);
    illegal_d = (cause_d != CauseNone);
  end

  assign in_pld = {in_pc, in_inst, imm_d, illegal_d, cause_d};

  rv_skid_buffer #(
    .Width(PayloadW)
  ) u_skid (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_pld),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_pld)
  );

  assign {out_pc, out_inst, out_imm, out_illegal, out_cause} = out_pld;

  // Raw fields are slices of the registered instruction, so they reset to 0 with it.
  assign out_opcode  = out_inst[6:0];
  assign out_rd      = out_inst[11:7];
  assign out_funct3  = out_inst[14:12];
  assign out_rs1     = out_inst[19:15];
  assign out_rs2     = out_inst[24:20];
  assign out_funct7  = out_inst[31:25];
  assign out_funct12 = out_inst[31:20];

`ifdef RV_DECODE_STATS_EN
  logic out_fire;
  assign out_fire = out_valid & out_ready;

  // Saturating counters of output transfers and of illegal output transfers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_decoded <= '0;
      stat_illegal <= '0;
    end else if (out_fire) begin
      if (stat_decoded != 32'hffff_ffff) stat_decoded <= stat_decoded + 32'd1;
      if (out_illegal && stat_illegal != 32'hffff_ffff) stat_illegal <= stat_illegal + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv_decode_stage.sv
// Self-checking bench for rv_decode_stage. Runs an RV32 and an RV64 instance
// on the same stimulus; a scoreboard queue holds accepted instructions and is
// checked against each presented output.
module tb_rv_decode_stage;

  localparam int NV = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic        rand_rdy, rnd_bit, fixed_rdy, out_ready;
  assign out_ready = rand_rdy ? rnd_bit : fixed_rdy;

  always @(posedge clk) begin
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end

  logic        ird32, ov32, ill32;
  logic [31:0] pc32, inst32, imm32, sd32, si32;
  logic [6:0]  opc32, f7_32;
  logic [4:0]  rd32, rs1_32, rs2_32;
  logic [2:0]  f3_32, cause32;
  logic [11:0] f12_32;

  logic        ird64, ov64, ill64;
  logic [63:0] pc64, imm64;
  logic [31:0] inst64, sd64, si64;
  logic [6:0]  opc64, f7_64;
  logic [4:0]  rd64, rs1_64, rs2_64;
  logic [2:0]  f3_64, cause64;
  logic [11:0] f12_64;

  rv_decode_stage #(.XLEN(32), .PC_WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ird32), .in_inst(in_inst),
    .in_pc(in_pc[31:0]), .out_valid(ov32), .out_ready(out_ready), .out_pc(pc32),
    .out_inst(inst32), .out_opcode(opc32), .out_rd(rd32), .out_rs1(rs1_32), .out_rs2(rs2_32),
    .out_funct3(f3_32), .out_funct7(f7_32), .out_funct12(f12_32), .out_imm(imm32),
    .out_illegal(ill32), .out_cause(cause32)
`ifdef RV_DECODE_STATS_EN
    , .stat_decoded(sd32), .stat_illegal(si32)
`endif
  );

  rv_decode_stage #(.XLEN(64), .PC_WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ird64), .in_inst(in_inst),
    .in_pc(in_pc), .out_valid(ov64), .out_ready(out_ready), .out_pc(pc64),
    .out_inst(inst64), .out_opcode(opc64), .out_rd(rd64), .out_rs1(rs1_64), .out_rs2(rs2_64),
    .out_funct3(f3_64), .out_funct7(f7_64), .out_funct12(f12_64), .out_imm(imm64),
    .out_illegal(ill64), .out_cause(cause64)
`ifdef RV_DECODE_STATS_EN
    , .stat_decoded(sd64), .stat_illegal(si64)
`endif
  );

  // Directed vectors: instruction, expected 64-bit immediate (low half is the
  // RV32 value), expected cause under RV32 and under RV64.
  logic [31:0] v_inst [NV] = '{
    32'h00500093, 32'hFE000EE3, 32'h0080006F, 32'h0000B003, 32'h40001033, 32'h00100073,
    32'h00200073, 32'h00000000, 32'h800002B7, 32'hFE20AC23, 32'h4210D093, 32'h0010009B,
    32'h00001067, 32'h00500090, 32'h0010B023, 32'h40109093, 32'h403100B3};
  logic [63:0] v_imm [NV] = '{
    64'h5, 64'hFFFFFFFF_FFFFFFFC, 64'h8, 64'h0, 64'h400, 64'h1,
    64'h2, 64'h0, 64'hFFFFFFFF_80000000, 64'hFFFFFFFF_FFFFFFF8, 64'h421, 64'h1,
    64'h0, 64'h5, 64'h0, 64'h401, 64'h403};
  logic [2:0] v_c32 [NV] = '{3'd0, 3'd0, 3'd0, 3'd2, 3'd3, 3'd0, 3'd4, 3'd1, 3'd0, 3'd0,
                             3'd3, 3'd1, 3'd2, 3'd1, 3'd2, 3'd3, 3'd0};
  logic [2:0] v_c64 [NV] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd0, 3'd4, 3'd1, 3'd0, 3'd0,
                             3'd0, 3'd0, 3'd2, 3'd1, 3'd0, 3'd3, 3'd0};

  typedef struct {
    int          idx;
    logic [63:0] pc;
    int          cyc;
  } sb_t;

  sb_t         sbq[$];
  sb_t         mon_e;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          cur_idx = 0;
  int          n_out = 0, n_ill32 = 0, n_ill64 = 0;
  logic        lat_en = 1'b0;
  logic [63:0] pc_next = 64'h1_8000_0000;
  logic [31:0] mon_i;
  logic [63:0] mon_f;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: compare any presented output with the scoreboard head, pop on
  // transfer, then record the input accepted at the coming edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        cyc++;
        if (ov32) begin
          if (sbq.size() == 0) begin
            check_eq("spurious_out", 64'd1, 64'd0);
          end else begin
            mon_e = sbq[0];
            mon_i = v_inst[mon_e.idx];
            mon_f = {20'd0, mon_i[6:0], mon_i[11:7], mon_i[19:15], mon_i[24:20], mon_i[14:12],
                     mon_i[31:25], mon_i[31:20]};
            check_eq("valid64", ov64, 1);
            check_eq($sformatf("inst32[%0d]", mon_e.idx), inst32, mon_i);
            check_eq($sformatf("pc32[%0d]", mon_e.idx), pc32, mon_e.pc[31:0]);
            check_eq($sformatf("fields32[%0d]", mon_e.idx),
                     {opc32, rd32, rs1_32, rs2_32, f3_32, f7_32, f12_32}, mon_f);
            check_eq($sformatf("imm32[%0d]", mon_e.idx), imm32, v_imm[mon_e.idx][31:0]);
            check_eq($sformatf("cause32[%0d]", mon_e.idx), cause32, v_c32[mon_e.idx]);
            check_eq($sformatf("illegal32[%0d]", mon_e.idx), ill32, v_c32[mon_e.idx] != 3'd0);
            check_eq($sformatf("inst64[%0d]", mon_e.idx), inst64, mon_i);
            check_eq($sformatf("pc64[%0d]", mon_e.idx), pc64, mon_e.pc);
            check_eq($sformatf("fields64[%0d]", mon_e.idx),
                     {opc64, rd64, rs1_64, rs2_64, f3_64, f7_64, f12_64}, mon_f);
            check_eq($sformatf("imm64[%0d]", mon_e.idx), imm64, v_imm[mon_e.idx]);
            check_eq($sformatf("cause64[%0d]", mon_e.idx), cause64, v_c64[mon_e.idx]);
            check_eq($sformatf("illegal64[%0d]", mon_e.idx), ill64, v_c64[mon_e.idx] != 3'd0);
            if (out_ready) begin
              if (lat_en) check_eq("latency", cyc - mon_e.cyc, 1);
              n_out++;
              if (v_c32[mon_e.idx] != 3'd0) n_ill32++;
              if (v_c64[mon_e.idx] != 3'd0) n_ill64++;
              void'(sbq.pop_front());
            end
          end
        end
        if (in_valid && ird32) begin
          check_eq("in_ready64", ird64, 1);
          sbq.push_back('{idx: cur_idx, pc: in_pc, cyc: cyc});
          check_eq("occupancy_le2", sbq.size() <= 2, 1);
        end
      end
    end
  end

  // Present one vector (called at posedge+1) and hold it until accepted.
  task automatic send(input int idx);
    int t = 0;
    cur_idx  = idx;
    in_inst  = v_inst[idx];
    in_pc    = pc_next;
    in_valid = 1'b1;
    @(negedge clk);
    while (!ird32 && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (t >= 200) check_eq("send_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pc_next  = pc_next + 64'd4;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sbq.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check_eq("drain_empty", sbq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_out_valid32"}, ov32, 0);
    check_eq({tag, "_out_valid64"}, ov64, 0);
    check_eq({tag, "_in_ready32"}, ird32, 1);
    check_eq({tag, "_in_ready64"}, ird64, 1);
    check_eq({tag, "_inst32"}, inst32, 0);
    check_eq({tag, "_imm64"}, imm64, 0);
    check_eq({tag, "_pc64"}, pc64, 0);
    check_eq({tag, "_cause32"}, {ill32, cause32}, 0);
`ifdef RV_DECODE_STATS_EN
    check_eq({tag, "_stats32"}, {sd32, si32}, 0);
    check_eq({tag, "_stats64"}, {sd64, si64}, 0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = '0;
    in_pc     = '0;
    rand_rdy  = 1'b0;
    rnd_bit   = 1'b0;
    fixed_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("por");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Full-rate directed stream: every output exactly one cycle after accept.
    lat_en = 1'b1;
    for (int i = 0; i < NV; i++) send(i);
    wait_drain();
    lat_en = 1'b0;

    // Random backpressure and random input gaps.
    rand_rdy = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(int'($urandom_range(0, NV - 1)));
    end
    wait_drain();
    rand_rdy = 1'b0;

    // Stalled output: one extra accept, then in_ready drops and stays low.
    fixed_rdy = 1'b0;
    send(0);
    send(4);
    @(negedge clk);
    check_eq("bp_in_ready", ird32, 0);
    check_eq("bp_out_valid", ov32, 1);
    cur_idx  = 5;
    in_inst  = v_inst[5];
    in_pc    = pc_next;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("bp_hold_in_ready", ird32, 0);
    end
    @(posedge clk);
    #1 fixed_rdy = 1'b1;
    @(posedge clk);
    #1 fixed_rdy = 1'b0;
    @(negedge clk);
    check_eq("bp_ready_return", ird32, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pc_next  = pc_next + 64'd4;
    @(negedge clk);
    check_eq("full_in_ready", ird32, 0);
    check_eq("full_out_inst", inst32, v_inst[4]);

    // Reset with both entries occupied discards them.
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("midrst");
    sbq.delete();
    n_out   = 0;
    n_ill32 = 0;
    n_ill64 = 0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    fixed_rdy = 1'b1;
    lat_en    = 1'b1;
    send(1);
    send(8);
    send(9);
    send(3);
    send(10);
    wait_drain();

`ifdef RV_DECODE_STATS_EN
    check_eq("stat_decoded32", sd32, n_out);
    check_eq("stat_illegal32", si32, n_ill32);
    check_eq("stat_decoded64", sd64, n_out);
    check_eq("stat_illegal64", si64, n_ill64);
`endif
    check_eq("final_out_valid", ov32, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
